// File: rtl/stopwatch_bcd4_pkg.sv
// ----------------------------------------------------------------------------
// stopwatch_bcd4_pkg
// Shared types and helpers for the four-digit BCD stopwatch.
//   sw_state_t     : control states IDLE / RUN / PAUSE
//   DIGIT_W        : width of one BCD digit (4)
//   bcd_increment  : add one decimal count to a four-digit BCD value
//   blank_mask     : leading-zero blank request for a four-digit BCD value
// ----------------------------------------------------------------------------
package stopwatch_bcd4_pkg;

   localparam int DIGIT_W    = 4;
   localparam int NUM_DIGITS = 4;
   localparam int BCD_W      = DIGIT_W * NUM_DIGITS;

   localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   // Ripple a carry from the least significant digit upward. A digit at 9
   // (or, defensively, any non-BCD code) rolls to 0, so the result can
   // never contain A-F even if a register were upset.
   function automatic logic [BCD_W-1:0] bcd_increment(input logic [BCD_W-1:0] value);
      logic [BCD_W-1:0] result;
      logic             carry;
      result = value;
      carry  = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (value[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(9)) begin
               result[i*DIGIT_W +: DIGIT_W] = '0;
            end else begin
               result[i*DIGIT_W +: DIGIT_W] = value[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
               carry = 1'b0;
            end
         end
      end
      return result;
   endfunction

   // A digit is blanked only when it and every more significant digit are
   // zero. The least significant digit always shows, so 0000 reads "0".
   function automatic logic [NUM_DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] value);
      logic [NUM_DIGITS-1:0] mask;
      mask    = '0;
      mask[3] = (value[15:12] == '0);
      mask[2] = mask[3] && (value[11:8] == '0);
      mask[1] = mask[2] && (value[7:4] == '0);
      return mask;
   endfunction

endpackage

// File: rtl/stopwatch_bcd4_key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// Synchronizes a raw active-low pushbutton, debounces it and emits a single
// registered press pulse per debounced press.
//   clock    : system clock
//   reset    : synchronous active-high reset
//   key_n_i  : raw asynchronous key, low = pressed
//   press_o  : one-cycle pulse on each accepted high-to-low transition
// ----------------------------------------------------------------------------
module key_debounce #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic key_n_i,
   output logic press_o
);

   localparam int               CNT_W   = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

   logic             sync1_q, sync2_q;
   logic             samp_q;           // previous synchronized sample
   logic [CNT_W-1:0] cnt_q, cnt_d;     // length of the current run of equal samples
   logic             level_q, level_d; // debounced key level
   logic             armed_q, armed_d; // a released level has been accepted since reset
   logic             press_q, press_d;

   // A new level is accepted once DEB_CYCLES identical samples have been seen.
   // The run counter saturates, so a held key re-accepts the same level every
   // cycle without ever producing a second pulse. Presses are only honoured
   // once a released level has been accepted after reset, which stops a key
   // held through reset from firing when reset lifts.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      cnt_d   = CNT_W'(1);
      level_d = level_q;
      armed_d = armed_q;
      press_d = 1'b0;
      if (sync2_q == samp_q) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end
      if (cnt_d == CNT_MAX) begin
         level_d = sync2_q;
         if (sync2_q) begin
            armed_d = 1'b1;
         end
         press_d = level_q && !sync2_q && armed_q;
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         samp_q  <= 1'b1;
         cnt_q   <= '0;
         level_q <= 1'b1;
         armed_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
         samp_q  <= sync2_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         armed_q <= armed_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/stopwatch_bcd4.sv
// ----------------------------------------------------------------------------
// stopwatch_bcd4
// Four-digit BCD stopwatch counting at TICK_HZ, controlled by a run/pause key
// and a clear key.
//   clock      : system clock, single domain
//   reset      : synchronous active-high reset
//   key_run_n  : raw run/pause pushbutton, active low
//   key_clr_n  : raw clear pushbutton, active low
//   bcd        : four BCD digits, [15:12] most significant
//   blank      : per-digit leading-zero blank request, bit i covers bcd[4i+3:4i]
//   running    : high while in RUN
//   wrap       : one-cycle pulse when the count rolls 9999 -> 0000
// ----------------------------------------------------------------------------
module stopwatch_bcd4
   import stopwatch_bcd4_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int TICK_HZ    = 10,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  key_run_n,
   input  logic                  key_clr_n,
   output logic [BCD_W-1:0]      bcd,
   output logic [NUM_DIGITS-1:0] blank,
   output logic                  running,
   output logic                  wrap
);

   localparam int             PRE_RATIO = CLK_HZ / TICK_HZ;
   localparam int             PRE_W     = (PRE_RATIO > 1) ? $clog2(PRE_RATIO) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_RATIO - 1);

   logic run_press, clr_press;

   sw_state_t        state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic             wrap_q, wrap_d;
   logic             running_q, running_d;
   logic             tick;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_key (
      .clock   (clock),
      .reset   (reset),
      .key_n_i (key_run_n),
      .press_o (run_press)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_key (
      .clock   (clock),
      .reset   (reset),
      .key_n_i (key_clr_n),
      .press_o (clr_press)
   );

   assign tick = (state_q == RUN) && (pre_q == PRE_MAX);

   // Clear wins over everything: it zeroes the count and prescaler even when
   // a tick or a run press lands in the same cycle. A run press that
   // coincides with a tick still lets that tick count before pausing.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      bcd_d   = bcd_q;
      wrap_d  = 1'b0;
      case (state_q)
         IDLE: begin
            pre_d = '0;
            bcd_d = '0;
            if (!clr_press && run_press) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (clr_press) begin
               state_d = IDLE;
               pre_d   = '0;
               bcd_d   = '0;
            end else begin
               if (tick) begin
                  pre_d  = '0;
                  bcd_d  = bcd_increment(bcd_q);
                  wrap_d = (bcd_q == BCD_MAX);
               end else begin
                  pre_d = pre_q + PRE_W'(1);
               end
               if (run_press) begin
                  state_d = PAUSE;
               end
            end
         end
         PAUSE: begin
            // Prescaler holds, so resuming finishes the partial period.
            if (clr_press) begin
               state_d = IDLE;
               pre_d   = '0;
               bcd_d   = '0;
            end else if (run_press) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            pre_d   = '0;
            bcd_d   = '0;
         end
      endcase
      running_d = (state_d == RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         pre_q     <= '0;
         bcd_q     <= '0;
         wrap_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         bcd_q     <= bcd_d;
         wrap_q    <= wrap_d;
         running_q <= running_d;
      end
   end

   assign bcd     = bcd_q;
   assign running = running_q;
   assign wrap    = wrap_q;
   assign blank   = blank_mask(bcd_q);

endmodule

// File: tb/tb_stopwatch_bcd4.sv
// ----------------------------------------------------------------------------
// tb_stopwatch_bcd4
// Directed stimulus with a scoreboard. The stimulus thread pushes expected
// output snapshots; monitors pop and compare whenever the DUT outputs change
// (or when the stimulus requests a snapshot through probe). A second DUT with
// one tick per clock is used to reach the 9999 -> 0000 rollover quickly.
// ----------------------------------------------------------------------------
module tb_stopwatch_bcd4;

   localparam int CLK_HZ     = 100;
   localparam int TICK_HZ    = 10;
   localparam int DEB_CYCLES = 4;

   logic        clock     = 1'b0;
   logic        reset     = 1'b1;
   logic        key_run_n = 1'b1;
   logic        key_clr_n = 1'b1;
   logic        f_run_n   = 1'b1;
   logic        f_clr_n   = 1'b1;
   logic [15:0] bcd, f_bcd;
   logic [3:0]  blank, f_blank;
   logic        running, wrap, f_running, f_wrap;

   always #5 clock = ~clock;

   stopwatch_bcd4 #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEB_CYCLES(DEB_CYCLES)) dut (
      .clock     (clock),
      .reset     (reset),
      .key_run_n (key_run_n),
      .key_clr_n (key_clr_n),
      .bcd       (bcd),
      .blank     (blank),
      .running   (running),
      .wrap      (wrap)
   );

   stopwatch_bcd4 #(.CLK_HZ(CLK_HZ), .TICK_HZ(CLK_HZ), .DEB_CYCLES(DEB_CYCLES)) dut_fast (
      .clock     (clock),
      .reset     (reset),
      .key_run_n (f_run_n),
      .key_clr_n (f_clr_n),
      .bcd       (f_bcd),
      .blank     (f_blank),
      .running   (f_running),
      .wrap      (f_wrap)
   );

   typedef struct {
      logic [15:0] bcd;
      logic        running;
      logic        wrap;
      logic [3:0]  blank;
      int          gap;   // cycles since previous event, -1 = not checked
   } exp_t;

   typedef struct {
      logic [15:0] bcd;
      logic        wrap;
      logic [3:0]  blank;
      logic [15:0] prev;  // bcd one cycle before the event
   } fexp_t;

   exp_t  exp_q[$];
   fexp_t fexp_q[$];

   int checks = 0;
   int errors = 0;
   int nonbcd = 0;
   int now    = 0;
   bit mon_en = 1'b0;
   bit probe  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int n);
      return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
   endfunction

   function automatic logic [3:0] blank_of(input int n);
      return {n < 1000, n < 100, n < 10, 1'b0};
   endfunction

   task automatic push(input int n, input bit run, input bit wr, input int gap);
      exp_t e;
      e.bcd     = to_bcd(n);
      e.running = run;
      e.wrap    = wr;
      e.blank   = blank_of(n);
      e.gap     = gap;
      exp_q.push_back(e);
   endtask

   task automatic goto(input int t);
      while (now < t) begin
         @(negedge clock);
         now++;
      end
   endtask

   // Main monitor: any change of the output vector (or a probe) is an event.
   initial begin
      logic [21:0] last, cur;
      int          since, idx;
      exp_t        e;
      last  = {16'h0000, 1'b0, 1'b0, 4'b1110};
      since = 0;
      idx   = 0;
      forever begin
         @(posedge clock);
         #1;
         if (mon_en) begin
            cur = {bcd, running, wrap, blank};
            since++;
            for (int i = 0; i < 4; i++) begin
               if (bcd[i*4 +: 4] > 4'd9) nonbcd++;
            end
            if (cur !== last || probe) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL ev%0d unexpected: got %0h expected no event", idx, cur);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("ev%0d.bcd", idx), 32'(bcd), 32'(e.bcd));
                  check($sformatf("ev%0d.running", idx), 32'(running), 32'(e.running));
                  check($sformatf("ev%0d.wrap", idx), 32'(wrap), 32'(e.wrap));
                  check($sformatf("ev%0d.blank", idx), 32'(blank), 32'(e.blank));
                  if (e.gap >= 0) begin
                     check($sformatf("ev%0d.gap", idx), 32'(since), 32'(e.gap));
                  end
               end
               since = 0;
               idx++;
            end
            last = cur;
         end
      end
   end

   // Fast-DUT monitor: events are edges of wrap.
   initial begin
      logic        last_wrap;
      logic [15:0] prev_bcd;
      fexp_t       e;
      last_wrap = 1'b0;
      prev_bcd  = 16'h0000;
      forever begin
         @(posedge clock);
         #1;
         if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
               if (f_bcd[i*4 +: 4] > 4'd9) nonbcd++;
            end
            if (f_wrap !== last_wrap) begin
               if (fexp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL fast unexpected wrap edge: got %0b expected no event", f_wrap);
               end else begin
                  e = fexp_q.pop_front();
                  check("fast.bcd", 32'(f_bcd), 32'(e.bcd));
                  check("fast.wrap", 32'(f_wrap), 32'(e.wrap));
                  check("fast.blank", 32'(f_blank), 32'(e.blank));
                  check("fast.prev_bcd", 32'(prev_bcd), 32'(e.prev));
               end
            end
            last_wrap = f_wrap;
            prev_bcd  = f_bcd;
         end
      end
   end

   // Stimulus. Keys change on negedges; a key driven at negedge t is first
   // sampled at the next posedge, and a debounced press acts 7 edges later.
   initial begin
      fexp_t fe;
      int    budget;

      repeat (3) @(negedge clock);
      mon_en = 1'b1;
      reset  = 1'b0;
      repeat (2) @(negedge clock);
      push(0, 1'b0, 1'b0, -1);             // reset state snapshot
      probe = 1'b1;
      @(negedge clock);
      probe = 1'b0;
      repeat (10) @(negedge clock);
      now = 0;

      // Run press held 10 cycles: RUN, then 0001 and 0002 ten cycles apart.
      key_run_n = 1'b0;
      push(0, 1'b1, 1'b0, -1);
      push(1, 1'b1, 1'b0, 10);
      push(2, 1'b1, 1'b0, 10);
      goto(10);  key_run_n = 1'b1;

      // Press landing while the prescaler reads 6: pause, count frozen.
      goto(27);  key_run_n = 1'b0;
      push(2, 1'b0, 1'b0, 7);
      goto(33);  key_run_n = 1'b1;

      // Three-cycle glitch must be ignored.
      goto(50);  key_run_n = 1'b0;
      goto(53);  key_run_n = 1'b1;
      goto(70);  push(2, 1'b0, 1'b0, -1); probe = 1'b1;
      goto(71);  probe = 1'b0;

      // Resume: prescaler continues from 7, so the next count is 3 cycles on.
      goto(80);  key_run_n = 1'b0;
      push(2, 1'b1, 1'b0, -1);
      push(3, 1'b1, 1'b0, 3);
      for (int n = 4; n <= 42; n++) push(n, 1'b1, 1'b0, 10);
      goto(86);  key_run_n = 1'b1;

      // Run and clear in the same cycle at 0042: clear wins.
      goto(481); key_run_n = 1'b0; key_clr_n = 1'b0;
      push(0, 1'b0, 1'b0, 8);
      goto(487); key_run_n = 1'b1; key_clr_n = 1'b1;

      // Count from zero to 0105, covering blank patterns along the way.
      goto(500); key_run_n = 1'b0;
      push(0, 1'b1, 1'b0, -1);
      for (int n = 1; n <= 105; n++) push(n, 1'b1, 1'b0, 10);
      goto(506); key_run_n = 1'b1;

      // Reset mid-RUN with the run key held low through reset release.
      goto(1560); reset = 1'b1; key_run_n = 1'b0;
      push(0, 1'b0, 1'b0, -1);
      goto(1563); reset = 1'b0;
      goto(1600); key_run_n = 1'b1;
      goto(1610); push(0, 1'b0, 1'b0, -1); probe = 1'b1;
      goto(1611); probe = 1'b0;

      // Fresh press works; a clear landing on a tick suppresses the increment.
      goto(1620); key_run_n = 1'b0;
      push(0, 1'b1, 1'b0, -1);
      push(1, 1'b1, 1'b0, 10);
      goto(1626); key_run_n = 1'b1;
      goto(1640); key_clr_n = 1'b0;
      push(0, 1'b0, 1'b0, 10);
      goto(1646); key_clr_n = 1'b1;

      // Clear in IDLE changes nothing.
      goto(1670); key_clr_n = 1'b0;
      goto(1676); key_clr_n = 1'b1;
      goto(1690); push(0, 1'b0, 1'b0, -1); probe = 1'b1;
      goto(1691); probe = 1'b0;

      // Fast DUT counts one per cycle through 9999 -> 0000.
      goto(1700); f_run_n = 1'b0;
      fe.bcd = 16'h0000; fe.wrap = 1'b1; fe.blank = 4'b1110; fe.prev = 16'h9999;
      fexp_q.push_back(fe);
      fe.bcd = 16'h0001; fe.wrap = 1'b0; fe.blank = 4'b1110; fe.prev = 16'h0000;
      fexp_q.push_back(fe);
      goto(1706); f_run_n = 1'b1;

      budget = 0;
      while (fexp_q.size() != 0 && budget < 12000) begin
         @(negedge clock);
         budget++;
      end
      if (fexp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL fast_wrap_timeout: got %0d pending events expected 0", fexp_q.size());
      end

      repeat (20) @(negedge clock);
      check("main_queue_left", 32'(exp_q.size()), 32'd0);
      check("fast_queue_left", 32'(fexp_q.size()), 32'd0);
      check("nonbcd_digits", 32'(nonbcd), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_bcd4.md
STOPWATCH_BCD4 -- requirements
Module: stopwatch_bcd4

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 10, meaning count rate in Hz (one count per 0.1 s).
REQ-003 SHALL have parameter DEB_CYCLES, default 1000000, meaning clock cycles a key must be stable to be accepted (20 ms at 50 MHz).
REQ-004 SHALL have port clock  input  1  system clock; single clock domain.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port key_run_n  input  1  raw asynchronous pushbutton, active-low; each press toggles run/pause.
REQ-007 SHALL have port key_clr_n  input  1  raw asynchronous pushbutton, active-low; each press clears and stops.
REQ-008 SHALL have port bcd  output  16  four BCD digits for the 7-segment driver; [15:12] most significant, [3:0] least significant.
REQ-009 SHALL have port blank  output  4  per-digit leading-zero blank request, 1 = blank; bit i maps to bcd[4i+3:4i].
REQ-010 SHALL have port running  output  1  high while in state RUN.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse when count rolls 9999 -> 0000.

Function
REQ-012 SHALL pass each key through a 2-flop synchronizer, then accept a new level only after DEB_CYCLES consecutive identical synchronized samples.
REQ-013 SHALL generate a one-cycle press pulse on each debounced high-to-low transition; release generates nothing; a held key generates exactly one pulse.
REQ-014 SHALL implement states IDLE, RUN, PAUSE; reset state IDLE.
REQ-015 SHALL transition IDLE->RUN on run press; RUN->PAUSE on run press; PAUSE->RUN on run press; RUN or PAUSE ->IDLE on clr press; clr press in IDLE keeps IDLE, count stays 0.
REQ-016 SHALL give clr press priority over run press in the same cycle (result IDLE, count 0000).
REQ-017 SHALL run a prescaler 0..(CLK_HZ/TICK_HZ - 1) only in RUN, emitting an internal tick on the terminal value and wrapping to 0.
REQ-018 SHALL hold the prescaler value in PAUSE (resume continues the partial period) and clear it to 0 in IDLE.
REQ-019 SHALL increment bcd by one decimal count on each tick, registered, visible the cycle after the tick; each digit rolls 9->0 and carries to the next.
REQ-020 SHALL roll 9999 -> 0000 and assert wrap for exactly that one cycle; counting continues in RUN.
REQ-021 SHALL, on a clr press coinciding with a tick, clear bcd to 0000 and suppress the increment and any wrap pulse.
REQ-022 SHALL derive blank combinationally from registered bcd: blank[3]=(d3==0); blank[2]=(d3==0 && d2==0); blank[1]=(d3==0 && d2==0 && d1==0); blank[0]=0 always.
REQ-023 SHALL never produce a non-BCD digit (A-F) on bcd.

Reset
REQ-024 SHALL, on reset high at a clock edge, set state IDLE, bcd=0000, prescaler=0, wrap=0, running=0, blank=1110, debounced key levels=released (1), no press pulse.
REQ-025 SHALL treat reset asserted mid-count or mid-debounce identically to power-on reset, discarding any partial debounce window.
REQ-026 SHALL, with a key held low through reset release, produce no press pulse until the key is released and pressed again.

Structure
REQ-027 SHALL place the state enumeration (IDLE/RUN/PAUSE) and the BCD digit width constant (4) in a shared package.
REQ-028 SHALL implement synchronizer, debounce and press-pulse logic in sub-module key_debounce, instantiated once per key.
REQ-029 SHALL connect bcd directly to the data input of the board's 7-segment driver; no combinational path from key inputs to any output.

Verification (CLK_HZ=100, TICK_HZ=10, DEB_CYCLES=4)
REQ-030 SHALL cover: reset, run press held 10 cycles -> running=1, bcd=0001 10 cycles after entry to RUN, 0002 after 20.
REQ-031 SHALL cover: key_run_n glitch low for 3 cycles -> no press pulse, state unchanged, bcd unchanged.
REQ-032 SHALL cover: preload count via ticks to 9999 in RUN -> next tick gives bcd=0000, wrap high exactly 1 cycle, blank=1110.
REQ-033 SHALL cover: run press at prescaler=6 -> PAUSE, bcd frozen; run press again -> next increment after 3 more RUN cycles.
REQ-034 SHALL cover: debounced run and clr presses in the same cycle while bcd=0042 -> IDLE, bcd=0000, running=0.
REQ-035 SHALL cover: bcd=0105 -> blank=1000; bcd=0007 -> blank=1110; reset asserted mid-RUN -> all REQ-024 values next cycle.
